// File: rtl/div_ratio_detector.sv
// Measures period and high time of a divided clock in clk cycles; reports lock/error.
// Optional DIV_RATIO_SYNC_EN adds a 2-flop synchronizer in front of edge detection.
module div_ratio_detector #(
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             div_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, MEASURE, TRACK, LOCKED} state_t;

  localparam int               MW      = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_CNT);

  state_t           state, state_nx;
  logic             div_s, div_q, rise, fall;
  logic [CNT_W-1:0] cnt, hcnt, prev;
  logic [CNT_W:0]   diff;
  logic [MW-1:0]    match, match_nx, match_inc;
  logic             in_tol, ovf;
  logic             pv_nx, locked_nx, err_nx, load_prev;

`ifdef DIV_RATIO_SYNC_EN
  logic [1:0] sync_pipe;

  always_ff @(posedge clk or posedge res) begin
    if (res) sync_pipe <= '0;
    else     sync_pipe <= {sync_pipe[0], div_in};
  end

  assign div_s = sync_pipe[1];
`else
  assign div_s = div_in;
`endif

  assign rise = div_s & ~div_q;
  assign fall = ~div_s & div_q;

  // Extra bit keeps the absolute difference free of wrap.
  assign diff = (cnt >= prev) ? ({1'b0, cnt} - {1'b0, prev})
                              : ({1'b0, prev} - {1'b0, cnt});
  assign in_tol    = (diff <= TOL_V);
  assign match_inc = match + 1'b1;

  // A rise reloads cnt, so saturation only counts when no rise is present.
  assign ovf = (cnt == CNT_MAX) && !rise && (state != IDLE);

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    match_nx  = match;
    pv_nx     = 1'b0;
    locked_nx = locked;
    err_nx    = err;
    load_prev = 1'b0;
    if (ovf) begin
      state_nx  = IDLE;
      err_nx    = 1'b1;
      locked_nx = 1'b0;
      match_nx  = '0;
    end else if (rise) begin
      unique case (state)
        IDLE: state_nx = MEASURE;
        MEASURE: begin
          pv_nx     = 1'b1;
          load_prev = 1'b1;
          match_nx  = '0;
          state_nx  = TRACK;
        end
        TRACK: begin
          pv_nx     = 1'b1;
          load_prev = 1'b1;
          if (in_tol) begin
            match_nx = match_inc;
            if (match_inc == LOCK_V) begin
              state_nx  = LOCKED;
              locked_nx = 1'b1;
              err_nx    = 1'b0;
            end
          end else begin
            match_nx = '0;
          end
        end
        LOCKED: begin
          pv_nx     = 1'b1;
          load_prev = 1'b1;
          if (!in_tol) begin
            locked_nx = 1'b0;
            err_nx    = 1'b1;
            match_nx  = '0;
            state_nx  = TRACK;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      div_q        <= 1'b0;
      cnt          <= '0;
      hcnt         <= '0;
      prev         <= '0;
      match        <= '0;
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
    end else begin
      div_q <= div_s;
      if (rise)                cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      if (rise)                          hcnt <= CNT_W'(1);
      else if (div_s && hcnt != CNT_MAX) hcnt <= hcnt + 1'b1;
      if (fall)      high_time <= hcnt;
      if (pv_nx)     period    <= cnt;
      if (load_prev) prev      <= cnt;
      match        <= match_nx;
      period_valid <= pv_nx;
      locked       <= locked_nx;
      err          <= err_nx;
    end
  end

endmodule

// File: tb/tb_div_ratio_detector.sv
// Randomized bench for div_ratio_detector: TOL=0 and TOL=1 instances vs a run-length reference model.
module tb_div_ratio_detector;
  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;
`ifdef DIV_RATIO_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic             clk = 1'b0;
  logic             res, div_in;
  logic [CNT_W-1:0] period [2];
  logic [CNT_W-1:0] high_time [2];
  logic             pv [2], locked [2], err [2];

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  div_ratio_detector #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TOL(0)) dut0 (
    .clk(clk), .res(res), .div_in(div_in), .period(period[0]), .high_time(high_time[0]),
    .period_valid(pv[0]), .locked(locked[0]), .err(err[0]));

  div_ratio_detector #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TOL(1)) dut1 (
    .clk(clk), .res(res), .div_in(div_in), .period(period[1]), .high_time(high_time[1]),
    .period_valid(pv[1]), .locked(locked[1]), .err(err[1]));

  // Reference: instance k uses tolerance k. Lock = run of consecutive matching intervals >= LOCK_CNT.
  logic [2:0] hist;
  logic       s_last;
  bit         m_act [2], m_hasp [2], m_lock [2], m_err [2], m_pv [2];
  int         m_prev [2], m_run [2], m_el [2], m_per [2], m_high [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist   = '0;
    s_last = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_hasp[k] = 0; m_lock[k] = 0; m_err[k] = 0; m_pv[k] = 0;
      m_prev[k] = 0; m_run[k] = 0; m_el[k] = 0; m_per[k] = 0; m_high[k] = 0;
    end
  endtask

  task automatic model_step(input logic d);
    logic s, r, f;
    int   p, dd;
    hist   = {hist[1:0], d};
    s      = hist[SD];
    r      = s & ~s_last;
    f      = ~s & s_last;
    s_last = s;
    for (int k = 0; k < 2; k++) begin
      m_pv[k] = 0;
      if (m_el[k] < 100000) m_el[k]++;
      if (r) begin
        if (m_act[k]) begin
          p        = m_el[k];
          m_pv[k]  = 1;
          m_per[k] = p;
          if (m_hasp[k]) begin
            dd = (p > m_prev[k]) ? p - m_prev[k] : m_prev[k] - p;
            if (dd <= k) m_run[k]++;
            else begin
              if (m_lock[k]) m_err[k] = 1;
              m_run[k] = 0;
            end
            if (m_run[k] >= LOCK_CNT) begin
              if (!m_lock[k]) m_err[k] = 0;
              m_lock[k] = 1;
            end else m_lock[k] = 0;
          end
          m_hasp[k] = 1;
          m_prev[k] = p;
        end
        m_act[k] = 1;
        m_el[k]  = 0;
      end else if (m_act[k] && m_el[k] == CMAX) begin
        m_err[k] = 1; m_lock[k] = 0; m_act[k] = 0; m_hasp[k] = 0; m_run[k] = 0;
      end
      if (f) m_high[k] = (m_el[k] > CMAX) ? CMAX : m_el[k];
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pv%0d", k),     32'(pv[k]),        32'(m_pv[k]));
      chk($sformatf("period%0d", k), 32'(period[k]),    32'(m_per[k]));
      chk($sformatf("high%0d", k),   32'(high_time[k]), 32'(m_high[k]));
      chk($sformatf("locked%0d", k), 32'(locked[k]),    32'(m_lock[k]));
      chk($sformatf("err%0d", k),    32'(err[k]),       32'(m_err[k]));
    end
  endtask

  // One clk: drive at negedge, model the rising edge, compare at the next negedge.
  task automatic cyc(input logic d);
    div_in = d;
    @(posedge clk);
    model_step(d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic pulses(input int h, input int l, input int n);
    repeat (n) begin
      repeat (h) cyc(1'b1);
      repeat (l) cyc(1'b0);
    end
  endtask

  task automatic mid_reset();
    #2 res = 1'b1;
    model_reset();
    #1 check_outputs();
    @(negedge clk);
    res = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int h, l, n;
    bit alt;
    res    = 1'b1;
    div_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    res = 1'b0;

    pulses(4, 4, 10);
    chk("lock_div8", 32'(locked[0]), 32'd1);
    pulses(3, 3, 8);
    repeat (300) cyc(1'b0);
    chk("ovf_err", 32'(err[0]), 32'd1);
    pulses(4, 4, 10);

    pulses(4, 4, 3);
    cyc(1'b1); cyc(1'b1);
    mid_reset();
    pulses(4, 4, 10);

    repeat (8) begin
      pulses(4, 4, 1);
      pulses(5, 4, 1);
    end
    chk("alt_tol1_lock", 32'(locked[1]), 32'd1);
    chk("alt_tol0_lock", 32'(locked[0]), 32'd0);

    repeat (40) begin
      h   = $urandom_range(1, 6);
      l   = $urandom_range(1, 6);
      n   = $urandom_range(1, 8);
      alt = 1'($urandom_range(0, 1));
      repeat (n) begin
        pulses(h, l, 1);
        if (alt) pulses(h + 1, l, 1);
      end
      if ($urandom_range(0, 9) == 0) repeat (260) cyc(1'b0);
      if ($urandom_range(0, 19) == 0) begin
        cyc(1'b1);
        mid_reset();
      end
    end

    pulses(1, 1, 10);
    pulses(255, 0, 1);
    pulses(128, 127, 8);
    pulses(2, 2, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_ratio_detector.md
# div_ratio_detector

Measures the clock-division ratio and high time of a divided clock, counted in periods of the source clock. It sits at the receiving end of the team's frequency dividers, checks that a divided clock runs at the expected ratio, and reports lock/error status to control logic. Period and high time are reported every cycle of the divided clock. Lock is declared after a programmable number of consecutive matching periods.

## Interface
- CNT_W, 8: width of period/high-time counters; max measurable period 2^CNT_W−1.
- LOCK_CNT, 4: consecutive matching periods required to assert `locked` (1..15).
- TOL, 0: max allowed |new period − previous period| counted as a match.

- clk  input  1  source clock; all logic on rising edge.
- res  input  1  reset, asynchronous, active-high.
- div_in  input  1  divided clock under measurement, derived from clk.
- period  output  CNT_W  last measured rising-to-rising interval in clk cycles.
- high_time  output  CNT_W  last measured rising-to-falling interval in clk cycles.
- period_valid  output  1  one-cycle pulse when `period` updates.
- locked  output  1  ratio stable per LOCK_CNT/TOL.
- err  output  1  sticky: lock lost or counter overflow; cleared on next lock or res.

## Operation
- Sampled signal `div_s` (= div_in, or synchronizer output; see Configuration). `div_q` = div_s delayed one clk.
- rise = div_s & ~div_q; fall = ~div_s & div_q.
- `cnt` increments every clk, saturating at all-ones. On rise, cnt <= 1.
- `hcnt`: on rise, hcnt <= 1; increments while div_s high; on fall, high_time <= hcnt.
- States:
  - IDLE: waiting for first rise. On rise → MEASURE.
  - MEASURE: first interval in progress. On rise: period <= cnt, prev <= cnt, period_valid = 1, match <= 0 → TRACK.
  - TRACK: on rise, period <= cnt, period_valid = 1.
    - If |cnt − prev| ≤ TOL, match++. When match reaches LOCK_CNT → LOCKED, locked = 1, err = 0.
    - Otherwise match <= 0.
    - prev <= cnt in both cases.
  - LOCKED: on rise, period updates and period_valid pulses.
    - Mismatch → locked = 0, err = 1, match <= 0, → TRACK.
- Overflow: cnt reaching all-ones in any state other than IDLE → err = 1, locked = 0, match <= 0, state → IDLE. No period_valid is issued for the overflowed interval.
- Difference is computed unsigned at CNT_W+1 bits; no wrap.
- rise and overflow in the same cycle: rise wins, because cnt is reloaded before saturation is observed.

## Timing
- Reset values: period = 0, high_time = 0, period_valid = 0, locked = 0, err = 0, state IDLE, cnt = 0, hcnt = 0, match = 0.
- res asserted mid-measurement clears everything immediately, without waiting for clk. The first rise after deassertion is treated as the first edge (IDLE).
- period, period_valid, locked and err are registered. They change on the clk edge at which div_in is first sampled high (macro off).
- high_time updates on the clk edge at which div_in is first sampled low.
- period_valid is exactly one clk wide and pulses at most once per div_in period.
- Lock latency is LOCK_CNT+2 rising edges of div_in after IDLE.
- Minimum measurable div_in period is 2 clk cycles.

## Configuration
- DIV_RATIO_SYNC_EN defined: div_in passes through a 2-flop synchronizer (reset to 0) before edge detection. All output updates are delayed by 2 clk cycles. Measured values are unchanged.
- Undefined: div_in feeds edge detection directly (same-domain divided clock), with zero added latency.

## Test plan
- Divide-by-8 (div_in toggles every 4 clk), defaults → period = 8 and high_time = 4 on every pulse; locked = 1 at the 6th rise; err = 0.
- Locked at 8, switch to divide-by-6 → at the first 6-cycle rise: period = 6, locked = 0, err = 1. Relock (locked = 1, err = 0) 4 rises later.
- div_in held low after lock → cnt saturates at 255; err = 1, locked = 0, no further period_valid. Resumed toggling relocks after LOCK_CNT+2 rises.
- Assert res during TRACK → all outputs 0 before the next clk edge. After release, divide-by-8 relocks as in the first test.
- Periods alternating 8/9: TOL = 1 → locks and stays locked; TOL = 0 → locked never asserts, period_valid still pulses each rise.
- With DIV_RATIO_SYNC_EN, divide-by-8 → same period and high_time values, with each period_valid pulse 2 clk later than without the macro.
